ddr_rx_seq: RTL and testbench
=============================

# ddr_rx_seq

HDR-DDR receive sequencer that drives the RX deserializer through a complete target-to-controller read transfer: preamble, data words (two bytes + parity), and terminating CRC word (token + CRC5). It sits between the DDR CCC engine and RX. It issues `rx_en`/`rx_mode`, consumes `rx_mode_done`/`rx_pre`/`rx_error`, and writes received bytes into the register file. It reports transfer completion, error class and word count back to the engine.

## Interface
- MAX_WORDS, 16: maximum data words accepted before forced abort (1..255)
- ADDR_W, 8: register-file address width
- TIMEOUT_CYC, 1023: watchdog limit in i_sys_clk cycles per RX mode (only with RXSEQ_TIMEOUT_EN)
- i_sys_clk  in  1  system clock
- i_sys_rst  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse; begin a read transfer
- i_abort  in  1  synchronous abort request
- i_regf_base  in  ADDR_W  first register-file write address, sampled on i_start
- i_rx_mode_done  in  1  RX mode-complete pulse
- i_rx_pre  in  1  preamble bit from RX, valid with i_rx_mode_done
- i_rx_error  in  1  RX parity/token/CRC error, valid with i_rx_mode_done
- i_rx_data  in  8  deserialized byte, valid with i_rx_mode_done in byte states
- o_rx_en  out  1  RX enable
- o_rx_mode  out  4  RX mode: PREAMBLE 4'b0000, DESERIALIZING_BYTE 4'b0011, CHECK_TOKEN 4'b0101, CHECK_PAR_VALUE 4'b0110, CHECK_CRC_VALUE 4'b0111
- o_regf_wr_en  out  1  single-cycle byte write strobe
- o_regf_addr  out  ADDR_W  write address
- o_regf_data  out  8  write data
- o_busy  out  1  transfer in progress
- o_done  out  1  single-cycle pulse; transfer ended (good or bad)
- o_err  out  1  valid with o_done; 1 = transfer failed
- o_err_code  out  3  0 none, 1 parity, 2 token, 3 CRC, 4 overflow, 5 abort, 6 timeout
- o_word_count  out  8  data words received in the current/last transfer

## Operation
- States: IDLE, PRE1, PRE2, BYTE0, BYTE1, PARITY, TOKEN, CRC, FINISH.
- IDLE: o_rx_en=0, o_rx_mode=PREAMBLE. On i_start: latch i_regf_base, clear o_word_count and o_err_code, go to PRE1.
- PRE1 (PREAMBLE) on done: i_rx_pre=1 -> PRE2; i_rx_pre=0 -> TOKEN (CRC word follows).
- PRE2 (PREAMBLE) on done: i_rx_pre=1 -> BYTE0; i_rx_pre=0 -> FINISH with err 5 (target abort).
- BYTE0/BYTE1 (DESERIALIZING_BYTE) on done: write i_rx_data at current address, then increment address (wraps modulo 2^ADDR_W). BYTE0 -> BYTE1 -> PARITY.
- PARITY (CHECK_PAR_VALUE) on done: i_rx_error=1 -> FINISH, err 1. Otherwise increment o_word_count. If count reaches MAX_WORDS -> FINISH, err 4; else -> PRE1.
- TOKEN (CHECK_TOKEN) on done: error -> FINISH, err 2; else -> CRC.
- CRC (CHECK_CRC_VALUE) on done: error -> FINISH, err 3; else -> FINISH, err 0.
- FINISH: o_done=1 for one cycle, o_err=(code!=0), then IDLE.
- i_abort in any active state -> FINISH, err 5. Abort takes priority over a simultaneous i_rx_mode_done, and that byte is not written.
- i_start while o_busy is ignored. i_rx_mode_done in IDLE/FINISH is ignored.

## Timing
- Reset values: o_rx_en=0, o_rx_mode=4'b0000, o_regf_wr_en=0, o_regf_addr=0, o_regf_data=0, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_word_count=0; state IDLE.
- All outputs are registered.
- i_start at cycle N -> o_busy=1, o_rx_en=1, o_rx_mode=PREAMBLE at N+1.
- i_rx_mode_done at cycle N -> new o_rx_mode at N+1. For byte states, o_regf_wr_en/data/addr are also valid at N+1.
- o_rx_en stays high continuously between modes. It drops in the FINISH cycle, together with o_busy and o_done.
- Back-to-back start: i_start in the FINISH cycle is ignored. It is accepted from the first IDLE cycle.
- Reset asserted mid-transfer: immediate return to reset values, with no o_done pulse.

## Configuration
- RXSEQ_TIMEOUT_EN defined:
  - A 10+-bit counter clears on every state change and on i_rx_mode_done, and counts while in an active state.
  - Reaching TIMEOUT_CYC -> FINISH, err 6.
- Not defined: no counter; the block waits indefinitely for i_rx_mode_done, and code 6 is never produced.

## Test plan
- Base 8'h10, pre 1,1, bytes A5/3C, parity ok, pre 0, token ok, CRC ok -> writes 10:A5, 11:3C; o_done=1, o_err=0, o_word_count=1.
- Three words, parity error on the 2nd -> 4 writes; o_err_code=1, o_word_count=1; the mode after failure is not issued.
- MAX_WORDS=2, target keeps sending pre 1,1 -> after the 2nd parity, o_done with o_err_code=4, o_word_count=2.
- CRC word with i_rx_error at TOKEN -> code 2; repeat with the error at CRC -> code 3. Base 8'hFF with two bytes -> addresses FF, 00 (wrap).
- i_abort coincident with a BYTE1 done -> no write that cycle, code 5. Reset asserted mid-BYTE0 -> all outputs return to reset values next edge, with no o_done.
- With RXSEQ_TIMEOUT_EN and TIMEOUT_CYC=20, withhold done in PARITY -> o_done with code 6 at cycle 20; without the macro, o_busy stays high.

Source files
------------

// File: rtl/ddr_rx_seq.sv
// HDR-DDR receive sequencer: walks the RX deserializer through preamble, data words and CRC word,
// writing received bytes to the register file. Optional watchdog enabled by RXSEQ_TIMEOUT_EN.
module ddr_rx_seq #(
    parameter int MAX_WORDS = 16,
    parameter int ADDR_W    = 8
`ifdef RXSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1023
`endif
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_regf_base,
    input  logic              i_rx_mode_done,
    input  logic              i_rx_pre,
    input  logic              i_rx_error,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_en,
    output logic [3:0]        o_rx_mode,
    output logic              o_regf_wr_en,
    output logic [ADDR_W-1:0] o_regf_addr,
    output logic [7:0]        o_regf_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_err_code,
    output logic [7:0]        o_word_count
);

    localparam logic [3:0] MODE_PRE   = 4'b0000;
    localparam logic [3:0] MODE_BYTE  = 4'b0011;
    localparam logic [3:0] MODE_TOKEN = 4'b0101;
    localparam logic [3:0] MODE_PAR   = 4'b0110;
    localparam logic [3:0] MODE_CRC   = 4'b0111;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_PAR   = 3'd1;
    localparam logic [2:0] ERR_TOKEN = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;
    localparam logic [2:0] ERR_ABORT = 3'd5;

    localparam logic [7:0] LAST_WORD = 8'(MAX_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE1, S_PRE2, S_BYTE0, S_BYTE1, S_PARITY, S_TOKEN, S_CRC, S_FINISH
    } state_t;

    function automatic logic [3:0] mode_of(input state_t s);
        case (s)
            S_BYTE0, S_BYTE1: mode_of = MODE_BYTE;
            S_PARITY:         mode_of = MODE_PAR;
            S_TOKEN:          mode_of = MODE_TOKEN;
            S_CRC:            mode_of = MODE_CRC;
            default:          mode_of = MODE_PRE;
        endcase
    endfunction

    function automatic logic is_active(input state_t s);
        is_active = !(s == S_IDLE || s == S_FINISH);
    endfunction

    state_t              state;
    state_t              nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [2:0]          fin_code;
    logic                wr;
    logic                inc_word;

`ifdef RXSEQ_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    localparam logic [2:0] ERR_TMO = 3'd6;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    // Next-state decision; abort outranks a coincident mode-done so that byte is dropped.
    always_comb begin
        nxt      = state;
        fin_code = ERR_NONE;
        wr       = 1'b0;
        inc_word = 1'b0;
        case (state)
            S_IDLE:   if (i_start) nxt = S_PRE1;
            S_FINISH: nxt = S_IDLE;
            default: begin
                if (i_abort) begin
                    nxt      = S_FINISH;
                    fin_code = ERR_ABORT;
                end else if (i_rx_mode_done) begin
                    case (state)
                        S_PRE1: nxt = i_rx_pre ? S_PRE2 : S_TOKEN;
                        S_PRE2: begin
                            if (i_rx_pre) begin
                                nxt = S_BYTE0;
                            end else begin
                                nxt      = S_FINISH;
                                fin_code = ERR_ABORT;
                            end
                        end
                        S_BYTE0: begin
                            nxt = S_BYTE1;
                            wr  = 1'b1;
                        end
                        S_BYTE1: begin
                            nxt = S_PARITY;
                            wr  = 1'b1;
                        end
                        S_PARITY: begin
                            if (i_rx_error) begin
                                nxt      = S_FINISH;
                                fin_code = ERR_PAR;
                            end else begin
                                inc_word = 1'b1;
                                if (o_word_count == LAST_WORD) begin
                                    nxt      = S_FINISH;
                                    fin_code = ERR_OVF;
                                end else begin
                                    nxt = S_PRE1;
                                end
                            end
                        end
                        S_TOKEN: begin
                            nxt      = i_rx_error ? S_FINISH : S_CRC;
                            fin_code = i_rx_error ? ERR_TOKEN : ERR_NONE;
                        end
                        S_CRC: begin
                            nxt      = S_FINISH;
                            fin_code = i_rx_error ? ERR_CRC : ERR_NONE;
                        end
                        default: nxt = S_IDLE;
                    endcase
`ifdef RXSEQ_TIMEOUT_EN
                end else if (tmo_hit) begin
                    nxt      = S_FINISH;
                    fin_code = ERR_TMO;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            o_rx_en      <= 1'b0;
            o_rx_mode    <= MODE_PRE;
            o_regf_wr_en <= 1'b0;
            o_regf_addr  <= '0;
            o_regf_data  <= 8'h00;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= ERR_NONE;
            o_word_count <= 8'h00;
`ifdef RXSEQ_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            state        <= nxt;
            o_rx_mode    <= mode_of(nxt);
            o_rx_en      <= is_active(nxt);
            o_busy       <= is_active(nxt);
            o_done       <= (nxt == S_FINISH);
            o_err        <= (nxt == S_FINISH) && (fin_code != ERR_NONE);
            o_regf_wr_en <= wr;
            if (wr) begin
                o_regf_addr <= ptr;
                o_regf_data <= i_rx_data;
                ptr         <= ptr + 1'b1;
            end
            if (inc_word) o_word_count <= o_word_count + 8'd1;
            if (nxt == S_FINISH) o_err_code <= fin_code;
            if (state == S_IDLE && i_start) begin
                ptr          <= i_regf_base;
                o_word_count <= 8'h00;
                o_err_code   <= ERR_NONE;
            end
`ifdef RXSEQ_TIMEOUT_EN
            if (nxt != state || i_rx_mode_done || !is_active(state)) tmo_cnt <= '0;
            else                                                     tmo_cnt <= tmo_cnt + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_rx_seq.sv
// Table-driven bench for ddr_rx_seq (MAX_WORDS=2) plus hand-written reset and watchdog sequences.
module tb_ddr_rx_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 0, abort = 0, done = 0, pre = 0, err = 0;
    logic [7:0] base = 0, data = 0;

    logic       rx_en, regf_wr_en, busy, o_done, o_err;
    logic [3:0] rx_mode;
    logic [7:0] regf_addr, regf_data, word_count;
    logic [2:0] err_code;
    logic [35:0] outs;

    always #5 clk = ~clk;

    ddr_rx_seq #(
        .MAX_WORDS(2),
        .ADDR_W(8)
`ifdef RXSEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(20)
`endif
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .i_abort(abort),
        .i_regf_base(base), .i_rx_mode_done(done), .i_rx_pre(pre), .i_rx_error(err),
        .i_rx_data(data), .o_rx_en(rx_en), .o_rx_mode(rx_mode), .o_regf_wr_en(regf_wr_en),
        .o_regf_addr(regf_addr), .o_regf_data(regf_data), .o_busy(busy), .o_done(o_done),
        .o_err(o_err), .o_err_code(err_code), .o_word_count(word_count)
    );

    assign outs = {rx_en, rx_mode, regf_wr_en, regf_addr, regf_data, busy, o_done, o_err, err_code, word_count};

    typedef struct {
        logic        st, ab, dn, pr, er;
        logic [7:0]  bs, dt;
        logic [35:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic st, ab, dn, pr, er, input logic [7:0] bs, dt,
                       input logic en, input logic [3:0] md, input logic wr,
                       input logic [7:0] ad, wd, input logic bz, dq, eo,
                       input logic [2:0] cd, input logic [7:0] wc);
        vec_t v;
        v.st = st; v.ab = ab; v.dn = dn; v.pr = pr; v.er = er; v.bs = bs; v.dt = dt;
        v.exp = {en, md, wr, ad, wd, bz, dq, eo, cd, wc};
        vecs.push_back(v);
    endtask

    task automatic step(input logic st, ab, dn, pr, er, input logic [7:0] bs, dt);
        @(negedge clk);
        start = st; abort = ab; done = dn; pre = pr; err = er; base = bs; data = dt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // reset and idle-ignore checks
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h00,8'h00,0,0,0,3'd0,8'd0);
        add(0,0,1,1,1,8'h00,8'h99, 0,4'h0,0,8'h00,8'h00,0,0,0,3'd0,8'd0);
        add(0,1,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h00,8'h00,0,0,0,3'd0,8'd0);
        // one good word then CRC word, base 10
        add(1,0,0,0,0,8'h10,8'h00, 1,4'h0,0,8'h00,8'h00,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h00,8'h00,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h00,8'h00,1,0,0,3'd0,8'd0);
        add(0,0,0,0,0,8'h00,8'h00, 1,4'h3,0,8'h00,8'h00,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'hA5, 1,4'h3,1,8'h10,8'hA5,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h3C, 1,4'h6,1,8'h11,8'h3C,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h0,0,8'h11,8'h3C,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h5,0,8'h11,8'h3C,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h7,0,8'h11,8'h3C,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 0,4'h0,0,8'h11,8'h3C,0,1,0,3'd0,8'd1);
        add(1,0,0,0,0,8'h20,8'h00, 0,4'h0,0,8'h11,8'h3C,0,0,0,3'd0,8'd1);
        // parity error on second word, base 20
        add(1,0,0,0,0,8'h20,8'h00, 1,4'h0,0,8'h11,8'h3C,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h11,8'h3C,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h11,8'h3C,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h01, 1,4'h3,1,8'h20,8'h01,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h02, 1,4'h6,1,8'h21,8'h02,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h0,0,8'h21,8'h02,1,0,0,3'd0,8'd1);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h21,8'h02,1,0,0,3'd0,8'd1);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h21,8'h02,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h03, 1,4'h3,1,8'h22,8'h03,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h04, 1,4'h6,1,8'h23,8'h04,1,0,0,3'd0,8'd1);
        add(0,0,1,0,1,8'h00,8'h00, 0,4'h0,0,8'h23,8'h04,0,1,1,3'd1,8'd1);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h23,8'h04,0,0,0,3'd1,8'd1);
        // overflow at MAX_WORDS=2, base 30
        add(1,0,0,0,0,8'h30,8'h00, 1,4'h0,0,8'h23,8'h04,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h23,8'h04,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h23,8'h04,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h11, 1,4'h3,1,8'h30,8'h11,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h12, 1,4'h6,1,8'h31,8'h12,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h0,0,8'h31,8'h12,1,0,0,3'd0,8'd1);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h31,8'h12,1,0,0,3'd0,8'd1);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h31,8'h12,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h13, 1,4'h3,1,8'h32,8'h13,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h14, 1,4'h6,1,8'h33,8'h14,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,1,1,3'd4,8'd2);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,0,0,3'd4,8'd2);
        // token error
        add(1,0,0,0,0,8'h40,8'h00, 1,4'h0,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h5,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,1,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,1,1,3'd2,8'd0);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,0,0,3'd2,8'd0);
        // CRC error
        add(1,0,0,0,0,8'h40,8'h00, 1,4'h0,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h5,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h7,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,1,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,1,1,3'd3,8'd0);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h33,8'h14,0,0,0,3'd3,8'd0);
        // address wrap from FF
        add(1,0,0,0,0,8'hFF,8'h00, 1,4'h0,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h33,8'h14,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'hAA, 1,4'h3,1,8'hFF,8'hAA,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h55, 1,4'h6,1,8'h00,8'h55,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h0,0,8'h00,8'h55,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h5,0,8'h00,8'h55,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 1,4'h7,0,8'h00,8'h55,1,0,0,3'd0,8'd1);
        add(0,0,1,0,0,8'h00,8'h00, 0,4'h0,0,8'h00,8'h55,0,1,0,3'd0,8'd1);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h00,8'h55,0,0,0,3'd0,8'd1);
        // abort coincident with BYTE1 done
        add(1,0,0,0,0,8'h50,8'h00, 1,4'h0,0,8'h00,8'h55,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h00,8'h55,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h3,0,8'h00,8'h55,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h66, 1,4'h3,1,8'h50,8'h66,1,0,0,3'd0,8'd0);
        add(0,1,1,0,0,8'h00,8'h77, 0,4'h0,0,8'h50,8'h66,0,1,1,3'd5,8'd0);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h50,8'h66,0,0,0,3'd5,8'd0);
        // target abort: second preamble bit 0
        add(1,0,0,0,0,8'h60,8'h00, 1,4'h0,0,8'h50,8'h66,1,0,0,3'd0,8'd0);
        add(0,0,1,1,0,8'h00,8'h00, 1,4'h0,0,8'h50,8'h66,1,0,0,3'd0,8'd0);
        add(0,0,1,0,0,8'h00,8'h00, 0,4'h0,0,8'h50,8'h66,0,1,1,3'd5,8'd0);
        add(0,0,0,0,0,8'h00,8'h00, 0,4'h0,0,8'h50,8'h66,0,0,0,3'd5,8'd0);

        repeat (2) @(negedge clk);
        chk("reset_outputs", outs, 36'h0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].st, vecs[i].ab, vecs[i].dn, vecs[i].pr, vecs[i].er, vecs[i].bs, vecs[i].dt);
            chk($sformatf("vec%0d", i), outs, vecs[i].exp);
        end

        // reset asserted while in BYTE0
        step(1,0,0,0,0,8'h70,8'h00);
        step(0,0,1,1,0,8'h00,8'h00);
        step(0,0,1,1,0,8'h00,8'h00);
        chk("byte0_mode_before_reset", {busy, rx_mode}, {1'b1, 4'h3});
        @(negedge clk);
        done = 0; pre = 0;
        rst = 1'b0;
        #1;
        chk("async_reset_now", outs, 36'h0);
        @(posedge clk);
        #1;
        chk("async_reset_next_edge", outs, 36'h0);
        @(negedge clk);
        rst = 1'b1;

        // withhold done in PARITY
        step(1,0,0,0,0,8'h80,8'h00);
        step(0,0,1,1,0,8'h00,8'h00);
        step(0,0,1,1,0,8'h00,8'h00);
        step(0,0,1,0,0,8'h00,8'h01);
        step(0,0,1,0,0,8'h00,8'h02);
        chk("parity_entered", {busy, rx_mode}, {1'b1, 4'h6});
`ifdef RXSEQ_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            step(0,0,0,0,0,8'h00,8'h00);
            if (k == 19) chk("tmo_not_yet", {busy, o_done}, 2'b10);
        end
        chk("tmo_fire", {busy, o_done, o_err, err_code}, {3'b011, 3'd6});
        step(0,0,0,0,0,8'h00,8'h00);
        chk("tmo_idle", {busy, o_done}, 2'b00);
`else
        for (int k = 1; k <= 40; k++) begin
            step(0,0,0,0,0,8'h00,8'h00);
            if (k == 20 || k == 40) chk($sformatf("no_tmo_%0d", k), {busy, o_done}, 2'b10);
        end
        step(0,1,0,0,0,8'h00,8'h00);
        chk("abort_parity", {busy, o_done, o_err, err_code}, {3'b011, 3'd5});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
